// File: rtl/seven_segment_display.sv
// Multiplexed seven-segment driver: hex or decimal (sequential double-dabble),
// leading-zero blanking, per-digit decimal points and 16-level PWM brightness.
module seven_segment_display #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_BITS   = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rstN,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    decimalMode,
  input  logic                    blankLeadingZeros,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [3:0]              brightness,
  output logic [6:0]              segs,
  output logic                    dpOut,
  output logic [NUM_DIGITS-1:0]   sel,
  output logic                    busy
);

  localparam int VW    = 4 * NUM_DIGITS;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SH_W  = $clog2(VW);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [SH_W-1:0]  LAST_SHIFT = SH_W'(VW - 1);

  // 10**NUM_DIGITS always fits in VW bits because 10**n < 16**n.
  function automatic logic [VW-1:0] pow10(input int n);
    logic [VW-1:0] r;
    r = VW'(1);
    for (int k = 0; k < n; k++) r = r * VW'(10);
    return r;
  endfunction

  localparam logic [VW-1:0] DEC_LIMIT = pow10(NUM_DIGITS);

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    case (nib)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      default: glyph = 7'h71;
    endcase
  endfunction

  typedef enum logic [1:0] {LOAD, SHIFT, DONE} convState_e;

  logic [REFRESH_BITS-1:0] cnt;
  logic [IDX_W-1:0]        idx;
  logic [VW-1:0]           disp;
  logic                    ovf;
  convState_e              state;
  logic [VW-1:0]           bin;
  logic [VW-1:0]           bcd;
  logic [VW-1:0]           bcdAdj;
  logic                    ovfNext;
  logic [SH_W-1:0]         shiftCnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      if (cnt == '1) idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++)
      bcdAdj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state    <= LOAD;
      busy     <= 1'b0;
      disp     <= '0;
      ovf      <= 1'b0;
      bin      <= '0;
      bcd      <= '0;
      ovfNext  <= 1'b0;
      shiftCnt <= '0;
    end else if (!decimalMode) begin
      state <= LOAD;
      busy  <= 1'b0;
      disp  <= value;
      ovf   <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          bin      <= value;
          bcd      <= '0;
          ovfNext  <= (value >= DEC_LIMIT);
          shiftCnt <= '0;
          busy     <= 1'b1;
          state    <= SHIFT;
        end
        SHIFT: begin
          bcd      <= {bcdAdj[VW-2:0], bin[VW-1]};
          bin      <= {bin[VW-2:0], 1'b0};
          shiftCnt <= shiftCnt + 1'b1;
          if (shiftCnt == LAST_SHIFT) begin
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        default: begin
          disp  <= bcd;
          ovf   <= ovfNext;
          state <= LOAD;
        end
      endcase
    end
  end

  logic                  slotOn;
  logic [3:0]            curNib;
  logic                  curDp;
  logic                  curBlank;
  logic                  zeroAbove;
  logic [NUM_DIGITS-1:0] selOn;
  logic [6:0]            pattern;

  assign slotOn = (cnt[REFRESH_BITS-1 -: 4] <= brightness);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    curNib    = '0;
    curDp     = 1'b0;
    curBlank  = 1'b0;
    selOn     = '0;
    zeroAbove = 1'b1;
    // Walk from the most significant digit so zeroAbove covers nibble i and above.
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zeroAbove = zeroAbove && (disp[4*i +: 4] == 4'd0);
      if (idx == IDX_W'(i)) begin
        curNib   = disp[4*i +: 4];
        curDp    = dp[i];
        curBlank = zeroAbove && (i != 0);
        selOn[i] = slotOn;
      end
    end
    if (ovf)                                pattern = 7'h40;
    else if (blankLeadingZeros && curBlank) pattern = 7'h00;
    else                                    pattern = glyph(curNib);
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      segs  <= {7{SEG_ACTIVE_LOW}};
      dpOut <= SEG_ACTIVE_LOW;
      sel   <= {NUM_DIGITS{SEL_ACTIVE_LOW}};
    end else begin
      segs  <= SEG_ACTIVE_LOW ? ~pattern : pattern;
      dpOut <= SEG_ACTIVE_LOW ? ~curDp : curDp;
      sel   <= SEL_ACTIVE_LOW ? ~selOn : selOn;
    end
  end

endmodule

// File: tb/tb_seven_segment_display.sv
// Directed bench for seven_segment_display: 4 digits, 16-cycle slots, active-low outputs.
module tb_seven_segment_display;

  logic        clk = 1'b0;
  logic        rstN;
  logic [15:0] value;
  logic        decimalMode;
  logic        blankLeadingZeros;
  logic [3:0]  dp;
  logic [3:0]  brightness;
  logic [6:0]  segs;
  logic        dpOut;
  logic [3:0]  sel;
  logic        busy;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100,
                         G3 = 7'b0110000, G4 = 7'b0011001, G5 = 7'b0010010,
                         G6 = 7'b0000010, G7 = 7'b1111000, G8 = 7'b0000000,
                         G9 = 7'b0010000, GA = 7'b0001000, GB = 7'b0000011,
                         GC = 7'b1000110, GD = 7'b0100001, DASH = 7'b0111111,
                         BLANK = 7'h7F;

  seven_segment_display #(
    .NUM_DIGITS(4), .REFRESH_BITS(4), .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rstN(rstN), .value(value), .decimalMode(decimalMode),
    .blankLeadingZeros(blankLeadingZeros), .dp(dp), .brightness(brightness),
    .segs(segs), .dpOut(dpOut), .sel(sel), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Waits (bounded) until digit d is selected; the sel comparison fails on timeout.
  task automatic waitDigit(input int d);
    logic [3:0] want;
    want = ~(4'b0001 << d);
    for (int k = 0; k < 80; k++) begin
      @(posedge clk);
      #1;
      if (sel === want) break;
    end
    check($sformatf("sel_d%0d", d), {28'b0, sel}, {28'b0, want});
  endtask

  task automatic checkDigits(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                             input logic [6:0] e1, input logic [6:0] e0);
    logic [6:0] exp [4];
    exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
    for (int d = 3; d >= 0; d--) begin
      waitDigit(d);
      check($sformatf("%s_segs_d%0d", tag, d), {25'b0, segs}, {25'b0, exp[d]});
    end
  endtask

  task automatic countActive(input int n, output int act);
    act = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (sel !== 4'hF) act++;
    end
  endtask

  initial begin
    int act;
    int hi;
    int t;
    bit seenLow;

    rstN = 1'b0;
    value = 16'h12AB;
    decimalMode = 1'b0;
    blankLeadingZeros = 1'b0;
    dp = 4'b0000;
    brightness = 4'd15;
    #23;
    check("rst_sel", {28'b0, sel}, 32'hF);
    check("rst_segs", {25'b0, segs}, 32'h7F);
    check("rst_dp", {31'b0, dpOut}, 32'h1);
    check("rst_busy", {31'b0, busy}, 32'h0);
    rstN = 1'b1;

    // Hex display at full brightness.
    checkDigits("hex12AB", G1, G2, GA, GB);
    countActive(64, act);
    check("bright15", act, 64);

    brightness = 4'd0;
    cycles(2);
    countActive(64, act);
    check("bright0", act, 4);
    brightness = 4'd7;
    cycles(2);
    countActive(64, act);
    check("bright7", act, 32);
    brightness = 4'd15;

    // Leading-zero blanking and decimal points.
    value = 16'h0005;
    blankLeadingZeros = 1'b1;
    cycles(3);
    checkDigits("blank5", BLANK, BLANK, BLANK, G5);
    value = 16'h0000;
    cycles(3);
    checkDigits("blank0", BLANK, BLANK, BLANK, G0);
    dp = 4'b0100;
    cycles(3);
    for (int d = 3; d >= 0; d--) begin
      waitDigit(d);
      check($sformatf("dp_d%0d", d), {31'b0, dpOut}, (d == 2) ? 32'h0 : 32'h1);
    end
    blankLeadingZeros = 1'b0;
    dp = 4'b0000;

    // Decimal mode: busy width and conversion period.
    value = 16'd1234;
    decimalMode = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (busy === 1'b1) break;
    end
    check("busy_rise", {31'b0, busy}, 32'h1);
    hi = 1;
    t = 0;
    seenLow = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      t++;
      if (busy !== 1'b1) seenLow = 1'b1;
      else if (seenLow) break;
      else hi++;
    end
    check("busy_width", hi, 16);
    check("busy_period", t, 18);
    checkDigits("dec1234", G1, G2, G3, G4);

    value = 16'd10000;
    cycles(40);
    checkDigits("ovf10000", DASH, DASH, DASH, DASH);
    value = 16'd9999;
    cycles(40);
    checkDigits("dec9999", G9, G9, G9, G9);

    // Asynchronous reset in the middle of a conversion.
    value = 16'd5678;
    cycles(40);
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (busy === 1'b1) break;
    end
    cycles(5);
    #2;
    rstN = 1'b0;
    #1;
    check("midrst_sel", {28'b0, sel}, 32'hF);
    check("midrst_segs", {25'b0, segs}, 32'h7F);
    check("midrst_dp", {31'b0, dpOut}, 32'h1);
    check("midrst_busy", {31'b0, busy}, 32'h0);
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;
    check("restart_busy", {31'b0, busy}, 32'h1);
    cycles(40);
    checkDigits("dec5678", G5, G6, G7, G8);

    // Back to hex tracking.
    decimalMode = 1'b0;
    value = 16'hABCD;
    cycles(3);
    check("hex_busy", {31'b0, busy}, 32'h0);
    checkDigits("hexABCD", GA, GB, GC, GD);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_segment_display.md
# seven_segment_display

Parametrised multiplexed seven-segment driver for the board top level, generalising the fixed 4-digit hex display. Drives `NUM_DIGITS` common-select digits from one value bus in hex or decimal mode. Decimal mode uses a sequential double-dabble converter. Also supports leading-zero blanking, per-digit decimal points and 16-level PWM brightness. Sits beside the CPU and displays its display register.

## Interface
- `NUM_DIGITS`, 4: digits driven; value width is `4*NUM_DIGITS`.
- `REFRESH_BITS`, 16: digit slot lasts `2**REFRESH_BITS` cycles; must be >= 4.
- `SEG_ACTIVE_LOW`, 1: 1 = segment/dp outputs active-low.
- `SEL_ACTIVE_LOW`, 1: 1 = select outputs active-low.

Ports:
- `clk` in 1: system clock.
- `rstN` in 1: reset, asynchronous, active-low; one clock domain only.
- `value` in `4*NUM_DIGITS`: number to display, unsigned.
- `decimalMode` in 1: 0 = hex, 1 = decimal.
- `blankLeadingZeros` in 1: suppress leading zero digits.
- `dp` in `NUM_DIGITS`: decimal point per digit; bit 0 is the least significant digit.
- `brightness` in 4: on-time is `(brightness+1)/16` of each slot.
- `segs` out 7: `segs[0]`=a … `segs[6]`=g.
- `dpOut` out 1: decimal point of the active digit.
- `sel` out `NUM_DIGITS`: digit select, one-hot active.
- `busy` out 1: decimal conversion in progress.

## Operation
- **Scan**
  - `REFRESH_BITS`-bit counter `cnt` free-runs.
  - Digit index `idx` increments when `cnt` wraps to 0, and wraps from `NUM_DIGITS-1` to 0.
- **PWM**
  - Digit `idx` is selected while `cnt[REFRESH_BITS-1 -: 4] <= brightness`. Otherwise all selects are inactive.
  - `segs`/`dpOut` still show the digit's pattern while the selects are inactive.
- **Display register `disp`** (`4*NUM_DIGITS` bits of nibbles, plus `ovf` flag)
  - Hex mode: `disp <= value` and `ovf <= 0` every cycle.
  - Decimal mode: `disp` is written only by the converter.
- **Converter FSM, states LOAD → SHIFT → DONE → LOAD**
  - Runs continuously whenever `decimalMode`=1. When `decimalMode`=0 it is held in LOAD.
  - LOAD (1 cycle):
    - captures `value` into shift register `bin`;
    - clears BCD accumulator (`NUM_DIGITS` nibbles);
    - latches `ovfNext = (value >= 10**NUM_DIGITS)`.
  - SHIFT (`4*NUM_DIGITS` cycles): each cycle, add 3 to every BCD nibble >= 5, then shift `{bcd,bin}` left by 1. `busy`=1.
  - DONE (1 cycle): `disp <= bcd`, `ovf <= ovfNext`.
  - Conversion period is `4*NUM_DIGITS+2` cycles.
  - Changes to `value` during SHIFT are ignored until the next LOAD.
  - Clearing `decimalMode` mid-conversion aborts to LOAD. Hex tracking resumes the next cycle.
- **Glyphs**
  - Standard hex glyphs 0–9, A, b, C, d, E, F.
  - Overflow (`ovf`=1): every digit shows '-' (g only), with no blanking.
- **Blanking**
  - With `blankLeadingZeros`=1, digit i>0 is blank (all segments off) if nibble i and all higher nibbles are 0.
  - Digit 0 is never blanked.
  - `dp[i]` is still driven on blank digits.
- **Output polarity**: the `*_ACTIVE_LOW` parameters invert the final registered outputs.

## Timing
- **Reset, asynchronous.** While `rstN`=0:
  - `cnt`=0, `idx`=0, FSM=LOAD, `disp`=0, `ovf`=0, `busy`=0;
  - `sel`, `segs`, `dpOut` all inactive (all ones for active-low defaults).
  - This applies immediately, including mid-conversion and mid-slot.
- First cycle after release: the scan starts at digit 0, and `sel` goes active on the following cycle.
- `segs`, `dpOut` and `sel` are registered: 1-cycle latency from `cnt`/`idx`/`disp`.
- `busy` rises the cycle after LOAD and falls the cycle DONE is entered.
- A new decimal `disp` is visible on the outputs 1 cycle after DONE for the digit currently scanned.
- If a `cnt` wrap coincides with DONE, the new digit index uses the new `disp`.

## Test plan
All scenarios use `NUM_DIGITS`=4, `REFRESH_BITS`=4 and default polarities.
- **Hex:** `value`=16'h12AB, `brightness`=15, blanking off.
  - Digit 0: `sel`=4'b1110, `segs`=7'b0000011 ('b').
  - Digit 3: `sel`=4'b0111, `segs`=7'b1111001 ('1').
  - `sel` is active for all 16 cycles of each slot.
- **Decimal:** `value`=16'd1234, `decimalMode`=1.
  - `busy` is high for 16 cycles, with an 18-cycle period.
  - After DONE, digits 3..0 show 1, 2, 3, 4 ('4' = 7'b0011001).
- **Overflow:** `value`=16'd10000, decimal mode → all digits `segs`=7'b0111111. `value`=16'd9999 → 9, 9, 9, 9.
- **Blanking:** `value`=16'h0005 with blanking on.
  - Digits 3..1 show `segs`=7'h7F; digit 0 shows '5' (7'b0010010).
  - `value`=0 → only digit 0 lit, showing '0' (7'b1000000).
  - `dp`=4'b0100 → `dpOut`=0 on digit 2 only.
- **Brightness:** `brightness`=0 → `sel` active exactly 1 of 16 cycles per slot. `brightness`=7 → active 8 of 16.
- **Reset mid-conversion:** assert `rstN`=0 during SHIFT.
  - Outputs go inactive within the same cycle, and `busy`=0.
  - After release, the first conversion restarts from LOAD and yields the correct digits.
